// File: rtl/nn_pkg.sv
// Shared types and the Lowe ratio test used by the nearest-neighbour matcher
// and the ratio filter stages.
package nn_pkg;

  localparam int NUM_BITS   = 8;
  localparam int KEY_SIZE   = 4;
  localparam int DESC_BITS  = 8;
  localparam int COUNT_BITS = 16;

  typedef logic [DESC_BITS-1:0] corner_t;

  typedef struct packed {
    logic [KEY_SIZE-1:0] dist1;
    logic [KEY_SIZE-1:0] dist2;
    corner_t             a;
    corner_t             b;
  } match_t;

  localparam int MATCH_BITS = $bits(match_t);

  typedef enum logic {
    PASS,
    TRAILER
  } filt_state_t;

  // Product is formed at KEY_SIZE+2 bits so RATIO*dist1 cannot wrap for small ratios.
  function automatic logic lowe_accept(input match_t m, input int ratio, input int max_dist);
    logic [KEY_SIZE+1:0] d1_x;
    logic [KEY_SIZE+1:0] d2_x;
    logic [KEY_SIZE+1:0] lim;
    d1_x = {2'b00, m.dist1};
    d2_x = {2'b00, m.dist2};
    lim  = d1_x * (KEY_SIZE+2)'(ratio);
    return (int'(m.dist1) != NUM_BITS) && (int'(m.dist1) <= max_dist) && (d2_x >= lim);
  endfunction

endpackage

// File: rtl/nn_fifo.sv
// Synchronous FIFO with a registered head word: the output register is loaded
// with whatever will be at the head after this cycle's push/pop.
module nn_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == CW'(DEPTH));
  assign do_pop     = pop && valid;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push    = push && (!full || do_pop);
  assign rd_next    = rd_ptr + AW'(do_pop);
  assign count_next = count + CW'(do_push) - CW'(do_pop);

  // NOTE: storage has no reset; only pointers, count and the output registers need one.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      valid  <= (count_next != '0);
      // The incoming word becomes the head only when it lands on the new read slot.
      if (count_next != '0) begin
        if (do_push && (wr_ptr == rd_next)) rdata <= wdata;
        else                                rdata <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/nn_ratio_filter.sv
// Lowe ratio filter: forwards accepted matches and closes every frame with a
// trailer word carrying the number of matches accepted in that frame.
module nn_ratio_filter
  import nn_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int RATIO                  = 2,
  parameter int MAX_DIST               = 3,
  parameter int FIFO_DEPTH             = 4
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                s00_axis_tvalid,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  localparam int FIFO_W = C_M00_AXIS_TDATA_WIDTH + 1;

  filt_state_t           state;
  logic [COUNT_BITS-1:0] accept_cnt;
  match_t                beat;
  logic                  accept;
  logic                  in_fire;
  logic                  fifo_push;
  logic [FIFO_W-1:0]     fifo_wdata;
  logic                  fifo_full;
  logic                  fifo_valid;
  logic [FIFO_W-1:0]     fifo_rdata;
  logic                  unused_in;

  assign beat    = match_t'(s00_axis_tdata[MATCH_BITS-1:0]);
  assign accept  = lowe_accept(beat, RATIO, MAX_DIST);
  assign in_fire = s00_axis_tvalid && s00_axis_tready;

  assign s00_axis_tready = !s00_axis_areset && (state == PASS) && !fifo_full;
  assign unused_in       = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:MATCH_BITS]};

  always_comb begin
    // NOTE: defaults first so no latch is inferred on the paths that do not push.
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    if (state == PASS) begin
      fifo_push  = in_fire && accept;
      fifo_wdata = {1'b0, C_M00_AXIS_TDATA_WIDTH'(beat)};
    end else begin
      fifo_push  = !fifo_full;
      fifo_wdata = {1'b1, C_M00_AXIS_TDATA_WIDTH'({1'b1, 15'h0000, accept_cnt})};
    end
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state      <= PASS;
      accept_cnt <= '0;
    end else begin
      case (state)
        PASS: begin
          if (in_fire) begin
            if (accept && (accept_cnt != '1)) accept_cnt <= accept_cnt + 1'b1;
            if (s00_axis_tlast) state <= TRAILER;
          end
        end
        TRAILER: begin
          // The counter already includes the tlast beat by the time we get here.
          if (!fifo_full) begin
            accept_cnt <= '0;
            state      <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

  nn_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (s00_axis_aclk),
    .rst   (s00_axis_areset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .full  (fifo_full),
    .pop   (m00_axis_tready),
    .valid (fifo_valid),
    .rdata (fifo_rdata)
  );

  assign m00_axis_tvalid = fifo_valid;
  assign m00_axis_tlast  = fifo_rdata[FIFO_W-1];
  assign m00_axis_tdata  = fifo_rdata[C_M00_AXIS_TDATA_WIDTH-1:0];
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_nn_ratio_filter.sv
// Bench for nn_ratio_filter: a queue-based frame model checked on every output
// handshake, plus literal expectations for the directed frames.
module tb_nn_ratio_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_last, s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_strb;
  logic        m_ready, m_valid, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_strb;

  int          checks   = 0;
  int          failures = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
  longint      cyc      = 0;
  int          model_cnt = 0;
  logic [32:0] exp_q[$];
  logic [32:0] out_log[$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word  = '0;

  nn_ratio_filter dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_valid),
    .s00_axis_tlast  (s_last),
    .s00_axis_tdata  (s_data),
    .s00_axis_tstrb  (s_strb),
    .s00_axis_tready (s_ready),
    .m00_axis_tready (m_ready),
    .m00_axis_tvalid (m_valid),
    .m00_axis_tlast  (m_last),
    .m00_axis_tdata  (m_data),
    .m00_axis_tstrb  (m_strb)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A match survives when it has a real candidate, is close enough, and the
  // runner-up is at least twice as far away.
  function automatic bit model_accept(input logic [31:0] w);
    int d1 = int'(w[23:20]);
    int d2 = int'(w[19:16]);
    return (d1 != 8) && (d1 <= 3) && (d2 >= 2 * d1);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (rdy_mode == 2) m_ready = 1'($urandom_range(0, 1));
    else               m_ready = (rdy_mode == 0);
  end

  // Monitor/scoreboard: everything sampled at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_word});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", {m_last, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else                   check("out_word", {m_last, m_data}, exp_q.pop_front());
        out_log.push_back({m_last, m_data});
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
      if (s_valid && s_ready) begin
        if (model_accept(s_data)) begin
          exp_q.push_back({1'b0, 8'h00, s_data[23:0]});
          if (model_cnt < 65535) model_cnt++;
        end
        if (s_last) begin
          exp_q.push_back({1'b1, 16'h8000, 16'(model_cnt)});
          model_cnt = 0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 200) begin
        check("send_timeout", 64'(t), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    repeat (2) @(posedge clk);
    #2;
    while (exp_q.size() != 0 || m_valid) begin
      @(posedge clk);
      #2;
      t++;
      if (t > 5000) begin
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        break;
      end
    end
  endtask

  task automatic check_log(input int idx, input logic [32:0] exp);
    logic [63:0] act;
    act = (out_log.size() > idx) ? 64'(out_log[idx]) : 64'hFFFF_FFFF_FFFF_FFFF;
    check($sformatf("log[%0d]", idx), act, 64'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    logic [31:0] d;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_strb = '0; m_ready = 1'b1;

    // Reset state
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last",  m_last,  0);
    check("rst_m_data",  m_data,  0);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_strb",  m_strb,  4'hF);
    @(posedge clk); #1; rst = 1'b0;
    idle(2);

    // One accepted frame, then one rejected frame; first-word latency
    out_log.delete();
    send(32'h0014_A5A4, 1'b1);
    check("latency_valid", m_valid, 1);
    check("latency_data",  m_data,  32'h0014_A5A4);
    send(32'h0023_A5A4, 1'b1);
    wait_drain();
    check_log(0, {1'b0, 32'h0014_A5A4});
    check_log(1, {1'b1, 32'h8000_0001});
    check_log(2, {1'b1, 32'h8000_0000});
    check("log_size_a", 64'(out_log.size()), 3);

    // Sentinel and beyond-MAX_DIST frames: trailers only
    out_log.delete();
    send(32'h0088_5A5A, 1'b1);
    send(32'h0048_1234, 1'b1);
    wait_drain();
    check_log(0, {1'b1, 32'h8000_0000});
    check_log(1, {1'b1, 32'h8000_0000});
    check("log_size_b", 64'(out_log.size()), 2);

    // Ratio boundaries: d1=3/d2=6 kept, d1=3/d2=5 dropped, d1=0/d2=0 kept
    out_log.delete();
    send(32'h0036_5566, 1'b0);
    send(32'h0035_5566, 1'b0);
    send(32'h0000_1122, 1'b1);
    wait_drain();
    check_log(0, {1'b0, 32'h0036_5566});
    check_log(1, {1'b0, 32'h0000_1122});
    check_log(2, {1'b1, 32'h8000_0002});

    // Throughput: two 5-beat frames back to back cost 11 cycles
    out_log.delete();
    t0 = cyc;
    for (int i = 0; i < 10; i++) send(32'h0012_0000 | 32'(i), 1'((i % 5) == 4));
    check("throughput_cycles", 64'(cyc - t0), 11);
    wait_drain();
    check("log_size_tp", 64'(out_log.size()), 12);
    check_log(5, {1'b1, 32'h8000_0005});

    // Back-pressure: four beats fill the FIFO, then the input stalls
    out_log.delete();
    rdy_mode = 1;
    idle(2);
    for (int i = 0; i < 4; i++) send(32'h0013_0000 | 32'(i), 1'b0);
    s_valid = 1'b1; s_data = 32'h0013_0004; s_last = 1'b0;
    repeat (3) @(negedge clk);
    check("full_s_ready", s_ready, 0);
    check("full_m_valid", m_valid, 1);
    check("full_log_empty", 64'(out_log.size()), 0);
    rdy_mode = 0;
    for (int i = 4; i < 10; i++) send(32'h0013_0000 | 32'(i), 1'(i == 9));
    wait_drain();
    for (int i = 0; i < 10; i++) check_log(i, {1'b0, 32'h0013_0000 | 32'(i)});
    check_log(10, {1'b1, 32'h8000_000A});

    // Reset with three words buffered
    rdy_mode = 1;
    idle(2);
    for (int i = 0; i < 3; i++) send(32'h0014_0000 | 32'(i), 1'b0);
    @(posedge clk); #2;
    check("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_data",  m_data,  0);
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_strb",  m_strb,  4'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    out_log.delete();
    idle(2);
    send(32'h0013_ABCD, 1'b1);
    wait_drain();
    check_log(0, {1'b0, 32'h0013_ABCD});
    check_log(1, {1'b1, 32'h8000_0001});
    check("log_size_rst", 64'(out_log.size()), 2);

    // Random downstream stalls over 1000 beats
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      d[23:20] = 4'($urandom_range(0, 8));
      d[19:16] = 4'($urandom_range(0, 15));
      send(d, (i == 999) || ($urandom_range(0, 15) == 0));
    end
    wait_drain();
    rdy_mode = 0;
    check("final_queue_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
